// File: rtl/angle_range_reducer.sv
// rtl/angle_range_reducer.sv - multi-turn angle reduction and quadrant fold for the CORDIC sin/cos core
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   In_angle       signed input angle, HALF_PI input LSBs per pi/2
//   In_valid       input valid
//   In_ready       high only while idle
//   Reduced_angle  signed folded angle in [-HALF_PI, +HALF_PI]
//   Quadrant       quadrant 0..3 of the angle normalized to [0, 2pi)
//   Cos_negate     caller negates the CORDIC cosine result when high
//   Out_valid      result valid
//   Out_ready      downstream accepts the result

module angle_range_reducer #(
    parameter int IN_W      = 24,
    parameter int OUT_W     = 16,
    parameter int HALF_PI   = 25736,
    parameter int RED_STEPS = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  In_angle,
    input  logic             In_valid,
    output logic             In_ready,
    output logic [OUT_W-1:0] Reduced_angle,
    output logic [1:0]       Quadrant,
    output logic             Cos_negate,
    output logic             Out_valid,
    input  logic             Out_ready
);

    // Working width: wide enough to hold TWO_PI shifted by the largest step
    // without losing bits, so the restoring compare is exact.
    localparam int CW = IN_W + RED_STEPS;
    localparam int KW = (RED_STEPS > 1) ? $clog2(RED_STEPS) : 1;

    localparam logic [CW-1:0] C_HALF_PI = CW'(HALF_PI);
    localparam logic [CW-1:0] C_PI      = CW'(2 * HALF_PI);
    localparam logic [CW-1:0] C_PI3_2   = CW'(3 * HALF_PI);
    localparam logic [CW-1:0] C_TWO_PI  = CW'(4 * HALF_PI);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_FOLD   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic            r_sign;
    logic [IN_W-1:0] r_mag;
    logic [KW-1:0]   r_k;

    logic [IN_W-1:0]  w_abs;
    logic [CW-1:0]    w_mag_ext;
    logic [CW-1:0]    w_step;
    logic             w_ge;
    logic [CW-1:0]    w_r;
    logic [OUT_W-1:0] w_red;
    logic [1:0]       w_quad;
    logic             w_cneg;

    // Two's-complement magnitude; the most negative input maps to 2^(IN_W-1),
    // which still fits as an unsigned IN_W-bit value.
    assign w_abs     = In_angle[IN_W-1] ? (~In_angle + {{(IN_W-1){1'b0}}, 1'b1}) : In_angle;
    assign w_mag_ext = {{RED_STEPS{1'b0}}, r_mag};
    assign w_step    = C_TWO_PI << r_k;
    assign w_ge      = (w_mag_ext >= w_step);

    // Fold: negative angles map to TWO_PI - m, except that zero stays zero.
    // Differences are formed modulo 2^CW; the low OUT_W bits are the signed result.
    always_comb begin
        w_r    = (r_sign && (r_mag != '0)) ? (C_TWO_PI - w_mag_ext) : w_mag_ext;
        w_red  = '0;
        w_quad = 2'd0;
        w_cneg = 1'b0;
        if (w_r <= C_HALF_PI) begin
            w_red  = OUT_W'(w_r);
            w_quad = 2'd0;
            w_cneg = 1'b0;
        end else if (w_r <= C_PI) begin
            w_red  = OUT_W'(C_PI - w_r);
            w_quad = 2'd1;
            w_cneg = 1'b1;
        end else if (w_r <= C_PI3_2) begin
            w_red  = OUT_W'(C_PI - w_r);
            w_quad = 2'd2;
            w_cneg = 1'b1;
        end else begin
            w_red  = OUT_W'(w_r - C_TWO_PI);
            w_quad = 2'd3;
            w_cneg = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (In_valid) w_next_state = S_REDUCE;
            S_REDUCE: if (r_k == '0) w_next_state = S_FOLD;
            S_FOLD:   w_next_state = S_DONE;
            S_DONE:   if (Out_ready) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        In_ready  = (r_state == S_IDLE);
        Out_valid = (r_state == S_DONE);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign        <= 1'b0;
            r_mag         <= '0;
            r_k           <= '0;
            Reduced_angle <= '0;
            Quadrant      <= 2'd0;
            Cos_negate    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (In_valid) begin
                        r_sign <= In_angle[IN_W-1];
                        r_mag  <= w_abs;
                        r_k    <= KW'(RED_STEPS - 1);
                    end
                end
                S_REDUCE: begin
                    // Restoring step: subtract TWO_PI*2^k only when it does not underflow.
                    if (w_ge) begin
                        r_mag <= IN_W'(w_mag_ext - w_step);
                    end
                    if (r_k != '0) begin
                        r_k <= r_k - KW'(1);
                    end
                end
                S_FOLD: begin
                    Reduced_angle <= w_red;
                    Quadrant      <= w_quad;
                    Cos_negate    <= w_cneg;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
